// File: rtl/k2red_sched.sv
// k2red_sched: round-robin issue of 64-bit operands into a fixed-latency K2-RED pipeline,
// with requester-ID tracking, a credit-protected response FIFO and drained config swaps.
//   state    | meaning
//   ST_UNCFG | no valid configuration yet, no issue
//   ST_RUN   | issuing, config write accepted
//   ST_DRAIN | new config captured, waiting for in-flight ops to retire
//   ST_LOAD  | dp_* driven from shadow, settle countdown before RUN
module k2red_sched #(
   parameter int NREQ   = 4,
   parameter int LAT    = 6,
   parameter int DEPTH  = 8,
   parameter int SETTLE = 2,
   localparam int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [64*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 cfg_we,
   input  logic [31:0]          cfg_Q,
   input  logic [14:0]          cfg_k,
   input  logic [5:0]           cfg_m,
   output logic                 cfg_ready,
   output logic [63:0]          dp_A,
   output logic [31:0]          dp_Q,
   output logic [14:0]          dp_k,
   output logic [5:0]           dp_m,
   input  logic [31:0]          dp_C2,
   output logic                 rsp_valid,
   output logic [31:0]          rsp_data,
   output logic [IDW-1:0]       rsp_id,
   input  logic                 rsp_ready,
   output logic                 busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = (SETTLE > 2) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {ST_UNCFG, ST_RUN, ST_DRAIN, ST_LOAD} state_t;

   state_t                  state_q, state_d;
   logic [IDW-1:0]          ptr_q, ptr_d;
   logic [LAT-1:0]          vld_q, vld_d;
   logic [LAT-1:0][IDW-1:0] tag_q, tag_d;
   logic [CW-1:0]           inflight_q, inflight_d;
   logic [CW-1:0]           count_q, count_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]           settle_q, settle_d;
   logic [31:0]             shq_q, shq_d, dpq_q, dpq_d;
   logic [14:0]             shk_q, shk_d, dpk_q, dpk_d;
   logic [5:0]              shm_q, shm_d, dpm_q, dpm_d;
   logic [63:0]             dpa_q, dpa_d;
   logic [31:0]             mem_data_q [DEPTH];
   logic [IDW-1:0]          mem_id_q [DEPTH];
   logic [63:0]             req_word [NREQ];
   logic [IDW-1:0]          grant_idx, scan_idx;
   logic                    found, credit, issue, retire, pop;

   for (genvar g = 0; g < NREQ; g++) begin : g_word
      assign req_word[g] = req_data[64*g +: 64];
   end

   // Search starts one past the last grant so every requester gets a turn.
   always_comb begin
      found     = 1'b0;
      grant_idx = ptr_q;
      scan_idx  = ptr_q;
      for (int off = 1; off <= NREQ; off++) begin
         scan_idx = IDW'((int'(ptr_q) + off) % NREQ);
         if (!found && req_valid[scan_idx]) begin
            found     = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   always_comb begin
      cfg_ready = (state_q == ST_UNCFG) || (state_q == ST_RUN);
      credit    = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
      issue     = (state_q == ST_RUN) && !cfg_we && credit && found;
      req_ready = issue ? (NREQ'(1) << grant_idx) : '0;
      retire    = vld_q[LAT-1];
      pop       = (count_q != '0) && rsp_ready;
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      shq_d    = shq_q;
      shk_d    = shk_q;
      shm_d    = shm_q;
      dpq_d    = dpq_q;
      dpk_d    = dpk_q;
      dpm_d    = dpm_q;
      case (state_q)
         ST_UNCFG: if (cfg_we) begin
            shq_d    = cfg_Q;
            shk_d    = cfg_k;
            shm_d    = cfg_m;
            settle_d = SW'(SETTLE - 1);
            state_d  = ST_LOAD;
         end
         ST_RUN: if (cfg_we) begin
            shq_d   = cfg_Q;
            shk_d   = cfg_k;
            shm_d   = cfg_m;
            state_d = ST_DRAIN;
         end
         ST_DRAIN: if (inflight_q == '0) begin
            settle_d = SW'(SETTLE - 1);
            state_d  = ST_LOAD;
         end
         ST_LOAD: begin
            dpq_d = shq_q;
            dpk_d = shk_q;
            dpm_d = shm_q;
            if (settle_q == '0) state_d = ST_RUN;
            else                settle_d = settle_q - SW'(1);
         end
         default: state_d = ST_UNCFG;
      endcase

      dpa_d = issue ? req_word[grant_idx] : dpa_q;
      ptr_d = issue ? grant_idx : ptr_q;
      vld_d = {vld_q[LAT-2:0], issue};
      tag_d = {tag_q[LAT-2:0], grant_idx};

      case ({issue, retire})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
      case ({retire, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      wr_ptr_d = retire ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_UNCFG;
         ptr_q      <= IDW'(NREQ - 1);
         vld_q      <= '0;
         tag_q      <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         settle_q   <= '0;
         shq_q      <= '0;
         shk_q      <= '0;
         shm_q      <= '0;
         dpq_q      <= '0;
         dpk_q      <= '0;
         dpm_q      <= '0;
         dpa_q      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_data_q[i] <= '0;
            mem_id_q[i]   <= '0;
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         vld_q      <= vld_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         settle_q   <= settle_d;
         shq_q      <= shq_d;
         shk_q      <= shk_d;
         shm_q      <= shm_d;
         dpq_q      <= dpq_d;
         dpk_q      <= dpk_d;
         dpm_q      <= dpm_d;
         dpa_q      <= dpa_d;
         if (retire) begin
            mem_data_q[wr_ptr_q] <= dp_C2;
            mem_id_q[wr_ptr_q]   <= tag_q[LAT-1];
         end
      end
   end

   assign dp_A      = dpa_q;
   assign dp_Q      = dpq_q;
   assign dp_k      = dpk_q;
   assign dp_m      = dpm_q;
   assign rsp_valid = (count_q != '0);
   assign rsp_data  = mem_data_q[rd_ptr_q];
   assign rsp_id    = mem_id_q[rd_ptr_q];
   assign busy      = (state_q != ST_RUN) || (inflight_q != '0) || (count_q != '0);

endmodule

// File: tb/tb_k2red_sched.sv
// Self-checking bench for k2red_sched: scoreboard of accepted operands against returned responses.
module tb_k2red_sched;
   localparam int NREQ = 4, LAT = 6, DEPTH = 8, SETTLE = 2, IDW = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [64*NREQ-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic                cfg_we;
   logic [31:0]         cfg_Q;
   logic [14:0]         cfg_k;
   logic [5:0]          cfg_m;
   logic                cfg_ready;
   logic [63:0]         dp_A;
   logic [31:0]         dp_Q;
   logic [14:0]         dp_k;
   logic [5:0]          dp_m;
   logic [31:0]         dp_C2;
   logic                rsp_valid;
   logic [31:0]         rsp_data;
   logic [IDW-1:0]      rsp_id;
   logic                rsp_ready;
   logic                busy;
   logic [63:0]         word [NREQ];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NREQ; g++) begin : g_word
      assign req_data[64*g +: 64] = word[g];
   end

   k2red_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .cfg_we(cfg_we), .cfg_Q(cfg_Q), .cfg_k(cfg_k), .cfg_m(cfg_m), .cfg_ready(cfg_ready),
      .dp_A(dp_A), .dp_Q(dp_Q), .dp_k(dp_k), .dp_m(dp_m), .dp_C2(dp_C2),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
      .busy(busy));

   // Datapath stand-in: the operand registered at edge t is sampled back at edge t+LAT.
   logic [31:0] dp_pipe [LAT-1];
   always @(posedge clk) begin
      dp_pipe[0] <= dp_A[31:0];
      for (int i = 1; i < LAT-1; i++) dp_pipe[i] <= dp_pipe[i-1];
   end
   assign dp_C2 = dp_pipe[LAT-2];

   int n_chk = 0, n_pass = 0;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   logic [33:0] sb [$];
   int          grant_log [$];
   int          acc_cnt = 0, rsp_cnt = 0;

   // Handshakes are stable from the negedge until the next rising edge.
   always @(negedge clk) begin
      logic [33:0] e;
      if (rst) sb.delete();
      else begin
         if (req_ready != '0) check("ready_onehot", 64'($countones(req_ready)), 1);
         for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i]) begin
               sb.push_back({2'(i), word[i][31:0]});
               grant_log.push_back(i);
               acc_cnt++;
            end
         if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            check("sb_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("rsp_id", 64'(rsp_id), 64'(e[33:32]));
               check("rsp_data", 64'(rsp_data), 64'(e[31:0]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_words(input int j, input logic [31:0] base);
      for (int i = 0; i < NREQ; i++) word[i] = {~base, base + 32'(j*16 + i)};
   endtask

   initial begin
      int a0, r0, n, bad;
      rst = 1'b1; req_valid = '0; cfg_we = 1'b0; cfg_Q = '0; cfg_k = '0; cfg_m = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) word[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 64'(req_ready), 0);
      check("rst_cfg_ready", 64'(cfg_ready), 1);
      check("rst_dp_A", dp_A, 0);
      check("rst_dp_Q", 64'(dp_Q), 0);
      check("rst_rsp_valid", 64'(rsp_valid), 0);
      check("rst_busy", 64'(busy), 1);
      rst = 1'b0;

      // First configuration and single request from requester 2.
      req_valid = 4'b0100; word[2] = 64'h1234; rsp_ready = 1'b1;
      cfg_we = 1'b1; cfg_Q = 32'd7681; cfg_k = 15'd15; cfg_m = 6'd9;
      tick();
      cfg_we = 1'b0;
      check("t1_dp_Q_before", 64'(dp_Q), 0);
      tick();
      check("t1_dp_Q", 64'(dp_Q), 7681);
      check("t1_dp_k", 64'(dp_k), 15);
      check("t1_dp_m", 64'(dp_m), 9);
      check("t1_ready_settle", 64'(req_ready), 0);
      tick();
      check("t1_ready_first", 64'(req_ready), 4'b0100);
      tick();
      req_valid = '0;
      check("t1_dp_A", dp_A, 64'h1234);
      repeat (LAT-1) tick();
      check("t1_rsp_early", 64'(rsp_valid), 0);
      tick();
      check("t1_rsp_valid", 64'(rsp_valid), 1);
      check("t1_rsp_data", 64'(rsp_data), 64'h1234);
      check("t1_rsp_id", 64'(rsp_id), 2);
      repeat (2) tick();

      // All requesters streaming: pointer sits at 2, so grants run 3,0,1,2,...
      grant_log.delete();
      a0 = acc_cnt;
      req_valid = 4'hF;
      for (int j = 0; j < 12; j++) begin
         set_words(j, 32'hA000_0000);
         tick();
      end
      req_valid = '0;
      check("t2_issue_count", 64'(acc_cnt - a0), 12);
      for (int j = 0; j < 12 && j < grant_log.size(); j++)
         check("t2_grant_order", 64'(grant_log[j]), 64'((3 + j) % NREQ));
      repeat (LAT+4) tick();
      check("t2_sb_empty", 64'(sb.size()), 0);
      check("t2_busy_idle", 64'(busy), 0);

      // Backpressure: credit stops issue at DEPTH, one pop frees one slot.
      rsp_ready = 1'b0;
      a0 = acc_cnt; r0 = rsp_cnt;
      req_valid = 4'b0010;
      for (int j = 0; j < 14; j++) begin
         set_words(j, 32'hB000_0000);
         tick();
      end
      check("t3_acc_full", 64'(acc_cnt - a0), DEPTH);
      check("t3_ready_blocked", 64'(req_ready), 0);
      check("t3_rsp_valid", 64'(rsp_valid), 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         set_words(20 + j, 32'hB000_0000);
         tick();
      end
      check("t3_acc_after_pop", 64'(acc_cnt - a0), DEPTH + 1);
      check("t3_ready_blocked2", 64'(req_ready), 0);
      req_valid = '0; rsp_ready = 1'b1;
      repeat (DEPTH+LAT+4) tick();
      check("t3_sb_empty", 64'(sb.size()), 0);
      check("t3_rsp_cnt", 64'(rsp_cnt - r0), DEPTH + 1);

      // Reconfigure with five operations in flight.
      a0 = acc_cnt; r0 = rsp_cnt;
      req_valid = 4'b0001;
      for (int j = 0; j < 5; j++) begin
         set_words(j, 32'hC000_0000);
         tick();
      end
      cfg_we = 1'b1; cfg_Q = 32'd12289; cfg_k = 15'd3; cfg_m = 6'd12;
      tick();
      cfg_we = 1'b0;
      check("t4_acc_before_cfg", 64'(acc_cnt - a0), 5);
      n = 0;
      while (dp_Q == 32'd7681 && n < 20) begin
         check("t4_drain_no_issue", 64'(req_ready), 0);
         check("t4_drain_busy", 64'(busy), 1);
         tick();
         n++;
      end
      check("t4_drain_edges", 64'(n), 7);
      check("t4_acc_drain", 64'(acc_cnt - a0), 5);
      check("t4_rsp_old_cfg", 64'(rsp_cnt - r0), 5);
      check("t4_dp_Q", 64'(dp_Q), 12289);
      check("t4_dp_k", 64'(dp_k), 3);
      check("t4_dp_m", 64'(dp_m), 12);
      check("t4_ready_load", 64'(req_ready), 0);
      tick();
      check("t4_ready_run", 64'(req_ready), 4'b0001);
      check("t4_busy_run", 64'(busy), 0);
      tick();
      req_valid = '0;
      check("t4_acc_resume", 64'(acc_cnt - a0), 6);
      repeat (LAT+3) tick();
      check("t4_sb_empty", 64'(sb.size()), 0);

      // Asynchronous reset with 3 in flight and 2 queued.
      rsp_ready = 1'b0;
      req_valid = 4'b1000;
      for (int j = 0; j < 5; j++) begin
         set_words(j, 32'hD000_0000);
         tick();
      end
      req_valid = '0;
      repeat (3) tick();
      check("t5_queued", 64'(rsp_valid), 1);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_rsp_valid", 64'(rsp_valid), 0);
      check("t5_rst_rsp_data", 64'(rsp_data), 0);
      check("t5_rst_rsp_id", 64'(rsp_id), 0);
      check("t5_rst_dp_A", dp_A, 0);
      check("t5_rst_dp_Q", 64'(dp_Q), 0);
      check("t5_rst_cfg_ready", 64'(cfg_ready), 1);
      check("t5_rst_busy", 64'(busy), 1);
      #3 rst = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      bad = 0;
      for (int j = 0; j < 20; j++) begin
         set_words(j, 32'hE000_0000);
         tick();
         if (rsp_valid || req_ready != '0) bad++;
      end
      check("t5_quiet_after_rst", 64'(bad), 0);

      // Recovery: after reconfiguration requester 0 has first priority again.
      r0 = rsp_cnt;
      cfg_we = 1'b1; cfg_Q = 32'd7681; cfg_k = 15'd15; cfg_m = 6'd9;
      tick();
      cfg_we = 1'b0;
      repeat (SETTLE) tick();
      check("t5_first_grant", 64'(req_ready), 4'b0001);
      tick();
      req_valid = '0;
      repeat (LAT+2) tick();
      check("t5_rsp_cnt", 64'(rsp_cnt - r0), 1);
      check("t5_sb_empty", 64'(sb.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
